// File: rtl/native2axil_adapter_pkg.sv
// ----------------------------------------------------------------------------
// native2axil_adapter_pkg: shared types and constants for the native-to-AXI4-Lite bridge. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package native2axil_adapter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WRESP = 3'd2,
    ST_READ  = 3'd3,
    ST_RDATA = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

`default_nettype wire

// File: rtl/native2axil_adapter_if.sv
// ----------------------------------------------------------------------------
// native2axil_adapter_if: native request bus and AXI4-Lite bus bundles with master/slave views. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface native2axil_native_if
  import native2axil_adapter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic                valid;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic [DATA_W-1:0]   rdata;
  logic                ready;
  logic                error;

  modport master (output valid, addr, wdata, wstrb, input  rdata, ready, error);
  modport slave  (input  valid, addr, wdata, wstrb, output rdata, ready, error);
endinterface

interface native2axil_axil_if
  import native2axil_adapter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

`default_nettype wire

// File: rtl/native2axil_adapter.sv
// ----------------------------------------------------------------------------
// native2axil_adapter: native slave request -> single AXI4-Lite write/read, one-cycle ready on completion. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module native2axil_adapter
  import native2axil_adapter_pkg::*;
#(
  parameter int AXIL_ADDR_W = DEF_ADDR_W,
  parameter int AXIL_DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  native2axil_native_if.slave nat,
  native2axil_axil_if.master  m_axil
);

  localparam int STRB_W = AXIL_DATA_W / 8;

  state_e                 state_q;
  logic [AXIL_ADDR_W-1:0] addr_q;
  logic [AXIL_DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0]      wstrb_q;
  logic [AXIL_DATA_W-1:0] rdata_q;
  logic                   awvalid_q;
  logic                   wvalid_q;
  logic                   bready_q;
  logic                   arvalid_q;
  logic                   rready_q;
  logic                   aw_done_q;
  logic                   w_done_q;
  logic                   ready_q;
  logic                   error_q;

  logic aw_hs;
  logic w_hs;

  assign aw_hs = awvalid_q & m_axil.awready;
  assign w_hs  = wvalid_q & m_axil.wready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (nat.valid) begin
            addr_q  <= nat.addr;
            wdata_q <= nat.wdata;
            wstrb_q <= nat.wstrb;
            if (|nat.wstrb) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= ST_WRITE;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= ST_READ;
            end
          end
        end
        ST_WRITE: begin
          // AW and W retire independently; the flags remember which one already went.
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b1;
            state_q   <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (m_axil.bvalid) begin
            bready_q <= 1'b0;
            error_q  <= resp_is_err(m_axil.bresp);
            ready_q  <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_READ: begin
          if (m_axil.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (m_axil.rvalid) begin
            rready_q <= 1'b0;
            rdata_q  <= m_axil.rdata;
            error_q  <= resp_is_err(m_axil.rresp);
            ready_q  <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        // The native valid still seen here belongs to the request just completed.
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_axil.awaddr  = addr_q;
  assign m_axil.awprot  = AXI_PROT_DEFAULT;
  assign m_axil.awvalid = awvalid_q;
  assign m_axil.wdata   = wdata_q;
  assign m_axil.wstrb   = wstrb_q;
  assign m_axil.wvalid  = wvalid_q;
  assign m_axil.bready  = bready_q;
  assign m_axil.araddr  = addr_q;
  assign m_axil.arprot  = AXI_PROT_DEFAULT;
  assign m_axil.arvalid = arvalid_q;
  assign m_axil.rready  = rready_q;

  assign nat.rdata = rdata_q;
  assign nat.ready = ready_q;
  assign nat.error = error_q;

endmodule

`default_nettype wire

// File: tb/tb_native2axil_adapter.sv
// ----------------------------------------------------------------------------
// tb_native2axil_adapter: native master + wait-state AXI4-Lite slave around the bridge, checked against a memory model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_native2axil_adapter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  native2axil_native_if nat_if ();
  native2axil_axil_if   axil_if ();

  native2axil_adapter dut (
    .clk    (clk),
    .rst    (rst),
    .nat    (nat_if),
    .m_axil (axil_if)
  );

  int checks   = 0;
  int failures = 0;

  int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic aw_got, w_got, b_armed, r_armed;
  logic [31:0] s_awaddr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [2:0]  s_awprot;
  logic [1:0]  s_rresp;
  bit   [31:0] smem [0:63];
  int n_aw = 0, n_ar = 0, n_b = 0, n_ready = 0, n_proto = 0;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = axil_if.awvalid & axil_if.awready;
  assign w_hs  = axil_if.wvalid & axil_if.wready;
  assign b_hs  = axil_if.bvalid & axil_if.bready;
  assign ar_hs = axil_if.arvalid & axil_if.arready;
  assign r_hs  = axil_if.rvalid & axil_if.rready;

  assign axil_if.awready = axil_if.awvalid && (aw_cnt >= aw_wait);
  assign axil_if.wready  = axil_if.wvalid && (w_cnt >= w_wait);
  assign axil_if.bvalid  = b_armed && (b_cnt >= b_wait);
  assign axil_if.bresp   = (s_awaddr[15:12] == 4'hE) ? 2'b10 : 2'b00;
  assign axil_if.arready = axil_if.arvalid && (ar_cnt >= ar_wait);
  assign axil_if.rvalid  = r_armed && (r_cnt >= r_wait);
  assign axil_if.rdata   = s_rdata;
  assign axil_if.rresp   = s_rresp;

  // AXI4-Lite slave: memory in the low region, SLVERR for addresses 0xExxx.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_armed <= 1'b0; r_armed <= 1'b0;
      s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0; s_awprot <= '0;
      s_rdata <= '0; s_rresp <= '0;
    end else begin
      aw_cnt <= (axil_if.awvalid && !axil_if.awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (axil_if.wvalid && !axil_if.wready) ? w_cnt + 1 : 0;
      ar_cnt <= (axil_if.arvalid && !axil_if.arready) ? ar_cnt + 1 : 0;
      b_cnt  <= (b_armed && !axil_if.bvalid) ? b_cnt + 1 : 0;
      r_cnt  <= (r_armed && !axil_if.rvalid) ? r_cnt + 1 : 0;
      if (aw_hs) begin
        aw_got <= 1'b1; s_awaddr <= axil_if.awaddr; s_awprot <= axil_if.awprot;
      end
      if (w_hs) begin
        w_got <= 1'b1; s_wdata <= axil_if.wdata; s_wstrb <= axil_if.wstrb;
      end
      if ((aw_got || aw_hs) && (w_got || w_hs) && !b_armed) b_armed <= 1'b1;
      if (b_hs) begin
        b_armed <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (ar_hs) begin
        r_armed <= 1'b1;
        s_rresp <= (axil_if.araddr[15:12] == 4'hE) ? 2'b10 : 2'b00;
        s_rdata <= (axil_if.araddr[15:12] == 4'hE) ? 32'hBAD0_BAD0 : smem[axil_if.araddr[7:2]];
      end
      if (r_hs) r_armed <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (b_hs && s_awaddr[15:12] != 4'hE)
      smem[s_awaddr[7:2]] <= (smem[s_awaddr[7:2]] & ~{{8{s_wstrb[3]}}, {8{s_wstrb[2]}}, {8{s_wstrb[1]}}, {8{s_wstrb[0]}}})
                           | (s_wdata & {{8{s_wstrb[3]}}, {8{s_wstrb[2]}}, {8{s_wstrb[1]}}, {8{s_wstrb[0]}}});
  end

  always @(posedge clk) begin
    if (aw_hs) n_aw <= n_aw + 1;
    if (ar_hs) n_ar <= n_ar + 1;
    if (b_hs) n_b <= n_b + 1;
    if (nat_if.ready) n_ready <= n_ready + 1;
    if ((axil_if.awvalid && aw_got) || (axil_if.wvalid && w_got) || (axil_if.arvalid && r_armed))
      n_proto <= n_proto + 1;
  end

  // Reference model: word memory, byte-strobe merge, error region, held read data.
  bit   [31:0] exp_mem [0:63];
  logic [31:0] exp_last_rdata = '0;

  function automatic void model_apply(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                                      output logic [31:0] erd, output logic eer);
    logic [31:0] cur;
    eer = (a[15:12] == 4'hE);
    cur = exp_mem[a[7:2]];
    if (s != 4'h0) begin
      if (!eer) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
        exp_mem[a[7:2]] = cur;
      end
    end else begin
      exp_last_rdata = eer ? 32'hBAD0_BAD0 : cur;
    end
    erd = exp_last_rdata;
  endfunction

  // Presents a request at the current negedge and counts negedges until ready.
  task automatic do_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd, output logic er, output int lat);
    int n;
    nat_if.valid = 1'b1; nat_if.addr = a; nat_if.wdata = d; nat_if.wstrb = s;
    lat = -1;
    n = 0;
    while (lat < 0 && n < 60) begin
      @(negedge clk);
      n++;
      if (nat_if.ready === 1'b1) lat = n;
    end
    rd = nat_if.rdata;
    er = nat_if.error;
  endtask

  task automatic gap();
    nat_if.valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({nat_if.ready, nat_if.error, nat_if.rdata} !== 34'h0) begin
      failures++; $display("FAIL reset_native: got %h exp 0", {nat_if.ready, nat_if.error, nat_if.rdata});
    end
    checks++;
    if ({axil_if.awvalid, axil_if.wvalid, axil_if.bready, axil_if.arvalid, axil_if.rready} !== 5'b0) begin
      failures++; $display("FAIL reset_axi_ctrl: got %b exp 00000",
                           {axil_if.awvalid, axil_if.wvalid, axil_if.bready, axil_if.arvalid, axil_if.rready});
    end
    checks++;
    if ({axil_if.awaddr, axil_if.wdata, axil_if.wstrb, axil_if.araddr} !== 100'h0) begin
      failures++; $display("FAIL reset_axi_data: got %h exp 0",
                           {axil_if.awaddr, axil_if.wdata, axil_if.wstrb, axil_if.araddr});
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_basic();
    logic [31:0] erd; logic eer; int n;
    model_apply(32'h10, 32'hDEAD_BEEF, 4'hF, erd, eer);
    nat_if.valid = 1'b1; nat_if.addr = 32'h10; nat_if.wdata = 32'hDEAD_BEEF; nat_if.wstrb = 4'hF;
    @(negedge clk);
    checks++;
    if ({axil_if.awvalid, axil_if.wvalid, axil_if.awaddr, axil_if.wdata, axil_if.wstrb} !== {2'b11, 32'h10, 32'hDEAD_BEEF, 4'hF}) begin
      failures++; $display("FAIL wr_cycle1_beats: got %h exp %h",
                           {axil_if.awvalid, axil_if.wvalid, axil_if.awaddr, axil_if.wdata, axil_if.wstrb},
                           {2'b11, 32'h10, 32'hDEAD_BEEF, 4'hF});
    end
    n = 1;
    while (nat_if.ready !== 1'b1 && n < 60) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n !== 3) begin failures++; $display("FAIL wr_latency: got %0d exp 3", n); end
    checks++;
    if (nat_if.error !== eer) begin failures++; $display("FAIL wr_error: got %b exp %b", nat_if.error, eer); end
    gap();
    checks++;
    if (nat_if.ready !== 1'b0) begin failures++; $display("FAIL wr_ready_pulse: got %b exp 0", nat_if.ready); end
    checks++;
    if ({s_awaddr, s_wdata, s_wstrb, s_awprot} !== {32'h10, 32'hDEAD_BEEF, 4'hF, 3'b000}) begin
      failures++; $display("FAIL wr_slave_seen: got %h exp %h", {s_awaddr, s_wdata, s_wstrb, s_awprot},
                           {32'h10, 32'hDEAD_BEEF, 4'hF, 3'b000});
    end
  endtask

  task automatic test_read_wait();
    logic [31:0] erd, rd; logic eer, er; int lat;
    model_apply(32'h20, 32'h1234_5678, 4'hF, erd, eer);
    do_txn(32'h20, 32'h1234_5678, 4'hF, rd, er, lat);
    gap();
    r_wait = 2;
    model_apply(32'h20, 32'h0, 4'h0, erd, eer);
    do_txn(32'h20, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (lat !== 5) begin failures++; $display("FAIL rd_wait_latency: got %0d exp 5", lat); end
    checks++;
    if ({rd, er} !== {erd, eer}) begin failures++; $display("FAIL rd_wait_data: got %h/%b exp %h/%b", rd, er, erd, eer); end
    r_wait = 0;
    gap();
  endtask

  task automatic test_w_late();
    logic [31:0] erd; logic eer; int n, aw0, b0, rdy0, p0;
    aw0 = n_aw; b0 = n_b; rdy0 = n_ready; p0 = n_proto;
    w_wait = 3;
    model_apply(32'h24, 32'hA5A5_0F0F, 4'h5, erd, eer);
    nat_if.valid = 1'b1; nat_if.addr = 32'h24; nat_if.wdata = 32'hA5A5_0F0F; nat_if.wstrb = 4'h5;
    repeat (2) @(negedge clk);
    checks++;
    if ({axil_if.awvalid, axil_if.wvalid} !== 2'b01) begin
      failures++; $display("FAIL wlate_valids: got %b exp 01", {axil_if.awvalid, axil_if.wvalid});
    end
    n = 2;
    while (nat_if.ready !== 1'b1 && n < 60) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n !== 6) begin failures++; $display("FAIL wlate_latency: got %0d exp 6", n); end
    gap();
    repeat (3) @(negedge clk);
    checks++;
    if ({n_aw - aw0, n_b - b0, n_ready - rdy0, n_proto - p0} !== {32'd1, 32'd1, 32'd1, 32'd0}) begin
      failures++; $display("FAIL wlate_counts: got aw=%0d b=%0d rdy=%0d proto=%0d exp 1 1 1 0",
                           n_aw - aw0, n_b - b0, n_ready - rdy0, n_proto - p0);
    end
    w_wait = 0;
  endtask

  task automatic test_slverr();
    logic [31:0] erd, rd; logic eer, er; int lat;
    model_apply(32'hE040, 32'h0, 4'h0, erd, eer);
    do_txn(32'hE040, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if ({rd, er} !== {erd, eer} || er !== 1'b1) begin
      failures++; $display("FAIL slverr_read: got %h/%b exp %h/%b", rd, er, erd, eer);
    end
    gap();
    model_apply(32'h14, 32'h0000_7700, 4'h2, erd, eer);
    do_txn(32'h14, 32'h0000_7700, 4'h2, rd, er, lat);
    checks++;
    if ({rd, er} !== {erd, eer} || er !== 1'b0) begin
      failures++; $display("FAIL slverr_then_ok: got %h/%b exp %h/%b", rd, er, erd, eer);
    end
    gap();
  endtask

  task automatic test_back_to_back();
    logic [31:0] erd, rd; logic eer, er; int lat, aw0, ar0, rdy0;
    aw0 = n_aw; ar0 = n_ar; rdy0 = n_ready;
    model_apply(32'h30, 32'hCAFE_F00D, 4'hF, erd, eer);
    do_txn(32'h30, 32'hCAFE_F00D, 4'hF, rd, er, lat);
    model_apply(32'h30, 32'h0, 4'h0, erd, eer);
    do_txn(32'h30, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL b2b_latency: got %0d exp 4", lat); end
    checks++;
    if ({rd, er} !== {erd, eer}) begin failures++; $display("FAIL b2b_data: got %h/%b exp %h/%b", rd, er, erd, eer); end
    gap();
    repeat (5) @(negedge clk);
    checks++;
    if ({n_aw - aw0, n_ar - ar0, n_ready - rdy0} !== {32'd1, 32'd1, 32'd2}) begin
      failures++; $display("FAIL b2b_counts: got aw=%0d ar=%0d rdy=%0d exp 1 1 2",
                           n_aw - aw0, n_ar - ar0, n_ready - rdy0);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] erd, rd; logic eer, er; int n, lat, b0;
    b0 = n_b;
    b_wait = 6;
    nat_if.valid = 1'b1; nat_if.addr = 32'h3C; nat_if.wdata = 32'h1111_2222; nat_if.wstrb = 4'hF;
    n = 0;
    while (axil_if.bready !== 1'b1 && n < 20) begin
      @(negedge clk); n++;
    end
    checks++;
    if (axil_if.bready !== 1'b1) begin failures++; $display("FAIL rstmid_reach_wresp: got %b exp 1", axil_if.bready); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({nat_if.ready, nat_if.error, nat_if.rdata, axil_if.bready, axil_if.awvalid, axil_if.wvalid,
         axil_if.arvalid, axil_if.rready} !== 39'h0) begin
      failures++; $display("FAIL rstmid_async_ctrl: got %h exp 0", {nat_if.ready, nat_if.error, nat_if.rdata,
                           axil_if.bready, axil_if.awvalid, axil_if.wvalid, axil_if.arvalid, axil_if.rready});
    end
    checks++;
    if ({axil_if.awaddr, axil_if.wdata, axil_if.wstrb, axil_if.araddr} !== 100'h0) begin
      failures++; $display("FAIL rstmid_async_data: got %h exp 0",
                           {axil_if.awaddr, axil_if.wdata, axil_if.wstrb, axil_if.araddr});
    end
    nat_if.valid = 1'b0;
    exp_last_rdata = '0;
    b_wait = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    model_apply(32'h20, 32'h0, 4'h0, erd, eer);
    do_txn(32'h20, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if ({lat, rd, er} !== {32'd3, erd, eer}) begin
      failures++; $display("FAIL rstmid_read_after: got lat=%0d %h/%b exp lat=3 %h/%b", lat, rd, er, erd, eer);
    end
    gap();
    checks++;
    if (n_b - b0 !== 0) begin failures++; $display("FAIL rstmid_no_bresp: got %0d exp 0", n_b - b0); end
  endtask

  task automatic test_random();
    logic [31:0] a, d, erd, rd; logic [3:0] s; logic eer, er; int lat, exp_lat, idx, aw0, ar0, rdy0;
    bit chained;
    chained = 1'b0;
    aw0 = n_aw; ar0 = n_ar; rdy0 = n_ready;
    for (int i = 0; i < 40; i++) begin
      idx = $urandom_range(0, 15);
      a = 32'(idx) << 2;
      if ($urandom_range(0, 4) == 0) a = a | 32'hE000;
      d = $urandom;
      s = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      aw_wait = $urandom_range(0, 3); w_wait = $urandom_range(0, 3); b_wait = $urandom_range(0, 3);
      ar_wait = $urandom_range(0, 3); r_wait = $urandom_range(0, 3);
      if (s != 4'h0) exp_lat = 3 + ((aw_wait > w_wait) ? aw_wait : w_wait) + b_wait;
      else           exp_lat = 3 + ar_wait + r_wait;
      if (chained) exp_lat = exp_lat + 1;
      else gap();
      model_apply(a, d, s, erd, eer);
      do_txn(a, d, s, rd, er, lat);
      checks++;
      if (lat !== exp_lat) begin failures++; $display("FAIL rand_latency[%0d]: got %0d exp %0d", i, lat, exp_lat); end
      checks++;
      if ({rd, er} !== {erd, eer}) begin
        failures++; $display("FAIL rand_result[%0d] a=%h s=%h: got %h/%b exp %h/%b", i, a, s, rd, er, erd, eer);
      end
      chained = 1'($urandom_range(0, 1));
    end
    gap();
    repeat (3) @(negedge clk);
    checks++;
    if ((n_aw - aw0) + (n_ar - ar0) !== 40 || n_ready - rdy0 !== 40) begin
      failures++; $display("FAIL rand_txn_count: got axi=%0d rdy=%0d exp 40 40", (n_aw - aw0) + (n_ar - ar0), n_ready - rdy0);
    end
    checks++;
    if (n_proto !== 0) begin failures++; $display("FAIL protocol_reissue: got %0d exp 0", n_proto); end
  endtask

  initial begin
    nat_if.valid = 1'b0; nat_if.addr = '0; nat_if.wdata = '0; nat_if.wstrb = '0;
    test_reset();
    test_write_basic();
    test_read_wait();
    test_w_late();
    test_slverr();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1);
  end

endmodule

`default_nettype wire
